clock_divider_mc: RTL and testbench
===================================

# clock_divider_mc

Multi-channel, run-time programmable clock/tick generator. It is the parametrised successor of the fixed single-frequency divider. It produces N_CH independent divided outputs from the 50 MHz system clock, each in square (50 % duty) or single-cycle pulse mode. Divide ratios are loaded over a simple write port and applied glitch-free at period boundaries. It sits beside the board clock and feeds displays, debouncers, UART baud ticks and test-speed slow clocks.

## Interface
- `N_CH`, default 4: number of channels.
- `CNT_W`, default 32: counter and ratio width.
- `CLK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `DEF_FREQ`, default 1: reset output frequency of every channel. `DEF_HALF = CLK_FREQ/(2*DEF_FREQ)` must be ≥1 and fit in `CNT_W`. Elaboration error otherwise.
- `clk`, input, 1: system clock. All logic runs on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `wr_en`, input, 1: one-cycle write strobe.
- `wr_ch`, input, clog2(N_CH) bits: target channel. Out-of-range values are ignored.
- `wr_half`, input, `CNT_W`: new half-period in clk cycles. 0 disables the channel.
- `wr_mode`, input, 1: 0 = square, 1 = pulse.
- `sync`, input, 1: one-cycle strobe that restarts all channels phase-aligned.
- `clk_div`, output, N_CH: divided outputs, registered.
- `tick`, output, N_CH: one-cycle pulse coincident with each rising edge of `clk_div[i]`.
- `pend`, output, N_CH: a written value is waiting to be applied.

## Operation
- Each channel has a shadow register {half, mode} written by the port, and an active register that drives the counter.
- Reset: counters = 0; active and shadow = {DEF_HALF, square}; `clk_div`, `tick` and `pend` all 0.
- Counter counts 0..active_half−1. When count == active_half−1 a terminal event occurs and the count returns to 0 on the next edge.
- Square mode: a terminal event toggles `clk_div[i]`. The period is 2·half cycles. `tick[i]` = 1 on the edge where `clk_div` goes 0→1.
- Pulse mode: `clk_div[i]` is high for exactly the one cycle following each terminal event. The period is half cycles and `tick[i]` equals `clk_div[i]`.
- Half = 1 in pulse mode gives `clk_div` constantly high and `tick` every cycle. Half = 1 in square mode gives clk/2.
- Write: the shadow updates on the edge where `wr_en` is sampled, and `pend[ch]` is set. The shadow is copied to active at the channel's next terminal event, at which point `pend` clears and the counter restarts at 0 with the new value. In square mode the pending copy happens only at a terminal event where `clk_div` goes 1→0, so the high phase is never truncated.
- Disabled channel (active half = 0): counter held at 0, `clk_div` and `tick` held at 0. A pending nonzero write is applied on the next edge without waiting for a terminal event.
- Writing 0 to a running channel: the channel stops at its next qualifying terminal event with `clk_div` = 0.
- Back-to-back writes to one channel before application: the last write wins and `pend` stays set.
- `sync`: on that edge every channel loads shadow→active, counter = 0, `clk_div` = 0, `tick` = 0, and `pend` = 0.
- `wr_en` and `sync` in the same cycle: the written value is included in the sync load.
- `rst` asserted mid-operation: all state returns to reset values immediately, with no partial period completion.

## Timing
- Latency from a terminal event to the `clk_div`/`tick` update: 1 clk.
- Square mode, half = 3, from reset release: `clk_div` rises after the 3rd edge, falls after the 6th, period 6.
- Latency from write to effect: the next qualifying terminal event. The worst case is 2·old_half cycles.
- Latency from `sync` to the first `tick`: half cycles in both modes.
- All outputs are glitch-free registers. `clk_div` is for logic enables or slow pins, not for the clock tree.

## Structure
- Package `clkdiv_pkg` holds `CLK_FREQ_DEF`, the mode constants `MODE_SQUARE`/`MODE_PULSE`, and the `half_from_freq()` function.
- Sub-module `clock_divider_ch` is one channel: shadow, active, counter and output logic. The top-level generates N_CH instances and decodes `wr_ch` into per-channel write strobes. `sync` is broadcast to all instances.

## Test plan
- Reset then idle, with N_CH=4, DEF_HALF set to 4 by test parameters → all channels square with period 8, `tick` every 8 cycles, `pend` = 0.
- Write ch1 half=2 mid high phase → `pend[1]` = 1 until the next falling edge, then period 4, with no truncated high phase.
- Write ch2 half=5 in pulse mode → `clk_div[2]` is 1 for one cycle every 5 cycles and `tick[2]` equals `clk_div[2]`.
- Write ch3 half=0, then half=3 → output stops low, then restarts one cycle after the second write with period 6.
- Write ch0 half=7 in the same cycle as `sync` → all counters reset, ch0 runs with period 14, and all other channels' rising edges are aligned at their half counts.
- Pull `rst` low mid-period and write `wr_ch` out of range → outputs clear asynchronously, and the out-of-range write changes nothing.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Mode encoding is the single bit stored in each channel's shadow/active register.
package clkdiv_pkg;

    localparam longint CLK_FREQ_DEF = 50_000_000;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Half-period in input-clock cycles for a requested output frequency; 0 if freq is 0.
    function automatic longint half_from_freq(input longint clk_freq, input longint freq);
        return (freq > 0) ? clk_freq / (2 * freq) : 64'sd0;
    endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: shadow/active {half, mode}, period counter and registered outputs.
// New settings take effect only at period boundaries so the output never glitches.
module clock_divider_ch
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] DEF_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             wr_mode,
    input  logic             sync,
    output logic             clk_div,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_half_q, act_half_d;
    logic [CNT_W-1:0] sh_half_q, sh_half_d;
    logic             act_mode_q, act_mode_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;

    logic running;
    logic terminal;
    logic qualify;
    logic apply;

    assign running  = (act_half_q != '0);
    assign terminal = running && (cnt_q == act_half_q - ONE);
    // Square mode only swaps settings on the falling edge so the high phase stays whole.
    assign qualify  = terminal && ((act_mode_q == MODE_PULSE) || div_q);
    assign apply    = sync || (pend_q && (!running || qualify));

    always_comb begin
        sh_half_d  = sh_half_q;
        sh_mode_d  = sh_mode_q;
        act_half_d = act_half_q;
        act_mode_d = act_mode_q;
        cnt_d      = terminal ? '0 : cnt_q + ONE;
        div_d      = div_q;
        tick_d     = 1'b0;
        pend_d     = pend_q || wr_en;

        if (wr_en) begin
            sh_half_d = wr_half;
            sh_mode_d = wr_mode;
        end

        if (!running) begin
            cnt_d = '0;
            div_d = 1'b0;
        end else if (act_mode_q == MODE_PULSE) begin
            div_d  = terminal;
            tick_d = terminal;
        end else if (terminal) begin
            div_d  = !div_q;
            tick_d = !div_q;
        end

        if (apply) begin
            // A sync load includes a write arriving in the same cycle.
            act_half_d = sync ? sh_half_d : sh_half_q;
            act_mode_d = sync ? sh_mode_d : sh_mode_q;
            cnt_d      = '0;
            pend_d     = wr_en && !sync;
            if (sync) begin
                div_d  = 1'b0;
                tick_d = 1'b0;
            end else begin
                // The boundary pulse survives only if the channel stays in pulse mode.
                div_d  = running && (act_mode_q == MODE_PULSE) &&
                         (sh_mode_q == MODE_PULSE) && (sh_half_q != '0);
                tick_d = div_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            act_half_q <= DEF_HALF;
            act_mode_q <= MODE_SQUARE;
            sh_half_q  <= DEF_HALF;
            sh_mode_q  <= MODE_SQUARE;
            pend_q     <= 1'b0;
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_half_q <= act_half_d;
            act_mode_q <= act_mode_d;
            sh_half_q  <= sh_half_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_div = div_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clock_divider_mc.sv
// N_CH independent programmable dividers sharing one write port and a common sync strobe.
// Channel select decoding lives here; each channel owns its own timing state.
module clock_divider_mc
    import clkdiv_pkg::*;
#(
    parameter int     N_CH     = 4,
    parameter int     CNT_W    = 32,
    parameter longint CLK_FREQ = CLK_FREQ_DEF,
    parameter longint DEF_FREQ = 1,
    localparam int    CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             wr_mode,
    input  logic             sync,
    output logic [N_CH-1:0]  clk_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);

    localparam longint DEF_HALF_L = half_from_freq(CLK_FREQ, DEF_FREQ);
    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_L);

    generate
        if (DEF_HALF_L < 1 || (DEF_HALF_L >> CNT_W) != 0) begin : g_bad_def_half
            $error("clock_divider_mc: default half-period must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic ch_wr;
            // Codes at or above N_CH match no channel and are dropped.
            assign ch_wr = wr_en && (32'(wr_ch) == gi);

            clock_divider_ch #(
                .CNT_W    (CNT_W),
                .DEF_HALF (DEF_HALF)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (ch_wr),
                .wr_half (wr_half),
                .wr_mode (wr_mode),
                .sync    (sync),
                .clk_div (clk_div[gi]),
                .tick    (tick[gi]),
                .pend    (pend[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_mc.sv
// Bench for clock_divider_mc: a 4-channel and a 3-channel instance share stimulus and are
// compared each cycle with a phase-position reference model.
module tb_clock_divider_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_half = '0;
    logic       wr_mode = 1'b0;
    logic       sync = 1'b0;

    logic [3:0] clk_div4, tick4, pend4;
    logic [2:0] clk_div3, tick3, pend3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clock_divider_mc #(.N_CH(4), .CNT_W(8), .CLK_FREQ(8), .DEF_FREQ(1)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_half(wr_half),
        .wr_mode(wr_mode), .sync(sync), .clk_div(clk_div4), .tick(tick4), .pend(pend4)
    );

    clock_divider_mc #(.N_CH(3), .CNT_W(8), .CLK_FREQ(8), .DEF_FREQ(1)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_half(wr_half),
        .wr_mode(wr_mode), .sync(sync), .clk_div(clk_div3), .tick(tick3), .pend(pend3)
    );

    // Model: t counts edges since the current setting took effect; outputs follow from t.
    int nch [2] = '{4, 3};
    int m_ah [2][4], m_am [2][4], m_sh [2][4], m_sm [2][4];
    int m_pend [2][4], m_t [2][4], m_div [2][4], m_tick [2][4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                m_ah[i][c] = 4; m_am[i][c] = 0; m_sh[i][c] = 4; m_sm[i][c] = 0;
                m_pend[i][c] = 0; m_t[i][c] = 0; m_div[i][c] = 0; m_tick[i][c] = 0;
            end
    endtask

    task automatic model_step(input bit we, input int ch, input int half, input int mode, input bit sy);
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < nch[i]; c++) begin
                bit w = we && (ch == c);
                if (sy) begin
                    if (w) begin m_sh[i][c] = half; m_sm[i][c] = mode; end
                    m_ah[i][c] = m_sh[i][c]; m_am[i][c] = m_sm[i][c];
                    m_t[i][c] = 0; m_div[i][c] = 0; m_tick[i][c] = 0; m_pend[i][c] = 0;
                    continue;
                end
                if (m_ah[i][c] == 0) begin
                    m_div[i][c] = 0; m_tick[i][c] = 0;
                    if (m_pend[i][c] != 0) begin
                        m_ah[i][c] = m_sh[i][c]; m_am[i][c] = m_sm[i][c];
                        m_pend[i][c] = 0; m_t[i][c] = 0;
                    end
                end else begin
                    int tn = m_t[i][c] + 1;
                    int h = m_ah[i][c];
                    int d, k, q;
                    if (m_am[i][c] == 0) begin
                        d = (tn / h) % 2;
                        k = (tn % (2 * h) == h) ? 1 : 0;
                        q = (tn % (2 * h) == 0) ? 1 : 0;
                    end else begin
                        d = (tn % h == 0) ? 1 : 0;
                        k = d;
                        q = d;
                    end
                    if (q != 0 && m_pend[i][c] != 0) begin
                        int nd = (m_am[i][c] == 1 && m_sm[i][c] == 1 && m_sh[i][c] != 0) ? 1 : 0;
                        m_ah[i][c] = m_sh[i][c]; m_am[i][c] = m_sm[i][c];
                        m_pend[i][c] = 0; m_t[i][c] = 0; m_div[i][c] = nd; m_tick[i][c] = nd;
                    end else begin
                        m_t[i][c] = tn; m_div[i][c] = d; m_tick[i][c] = k;
                    end
                end
                if (w) begin m_sh[i][c] = half; m_sm[i][c] = mode; m_pend[i][c] = 1; end
            end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_div [2], e_tick [2], e_pend [2];
        for (int i = 0; i < 2; i++) begin
            e_div[i] = '0; e_tick[i] = '0; e_pend[i] = '0;
            for (int c = 0; c < nch[i]; c++) begin
                e_div[i][c]  = (m_div[i][c] != 0);
                e_tick[i][c] = (m_tick[i][c] != 0);
                e_pend[i][c] = (m_pend[i][c] != 0);
            end
        end
        check({tag, " clk_div4"}, 32'(clk_div4), 32'(e_div[0]));
        check({tag, " tick4"},    32'(tick4),    32'(e_tick[0]));
        check({tag, " pend4"},    32'(pend4),    32'(e_pend[0]));
        check({tag, " clk_div3"}, 32'(clk_div3), 32'(e_div[1][2:0]));
        check({tag, " tick3"},    32'(tick3),    32'(e_tick[1][2:0]));
        check({tag, " pend3"},    32'(pend3),    32'(e_pend[1][2:0]));
    endtask

    // One clock: compare at the falling edge, drive, let the rising edge land, step the model.
    task automatic step(input string tag, input bit we, input int ch, input int half,
                        input int mode, input bit sy);
        check_outputs(tag);
        wr_en = we; wr_ch = 2'(ch); wr_half = 8'(half); wr_mode = 1'(mode); sync = sy;
        if (we || sy)
            $display("txn %s @%0t: wr_en=%0d ch=%0d half=%0d mode=%0d sync=%0d",
                     tag, $time, we, ch, half, mode, sy);
        @(posedge clk);
        model_step(we, ch, half, mode, sy);
        @(negedge clk);
        wr_en = 1'b0; sync = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Entered at a falling edge; reset lands between edges and is released on a falling edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        $display("txn %s @%0t: async reset", tag, $time);
        #1 check_outputs({tag, " async"});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1 check_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        idle("idle", 20);

        for (int k = 0; k < 20 && m_div[0][1] == 0; k++) idle("seek_high", 1);
        step("ch1_half2", 1'b1, 1, 2, 0, 1'b0);
        idle("ch1_run", 20);

        step("ch2_pulse5", 1'b1, 2, 5, 1, 1'b0);
        idle("ch2_run", 30);

        step("ch3_off", 1'b1, 3, 0, 0, 1'b0);
        idle("ch3_stop", 20);
        step("ch3_half3", 1'b1, 3, 3, 0, 1'b0);
        idle("ch3_run", 20);

        step("ch0_sync", 1'b1, 0, 7, 0, 1'b1);
        idle("sync_run", 40);

        idle("pre_rst", 3);
        async_reset("mid_rst");
        step("oor_wr", 1'b1, 3, 2, 0, 1'b0);
        idle("oor_run", 20);

        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 199);
            if (r == 0)
                async_reset("rnd");
            else
                step("rnd", r < 36, $urandom_range(0, 3), $urandom_range(0, 6),
                     $urandom_range(0, 1), $urandom_range(0, 59) == 0);
        end
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
